// File: rtl/mul_acc_pkg.sv
// ============================================================================
//  mul_acc_pkg
//  Shared types and saturating-add helper for the signed multiply-accumulate.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package mul_acc_pkg;

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    HOLD = 1'b1
  } acc_state_e;

  localparam int COUNT_W = 16;

  // Working width of sat_add; any accumulator up to SAT_W-1 bits fits.
  localparam int SAT_W = 64;
  localparam logic signed [SAT_W:0] SAT_ONE = 1;

  typedef struct packed {
    logic             clamped;
    logic [SAT_W-1:0] sum;
  } sat_res_t;

  function automatic int acc_w(input int wx, input int wy, input int g);
    return wx + wy + g;
  endfunction

  // Adds two sign-extended operands one bit wider than needed, then clamps
  // the result into the signed range of a w-bit accumulator.
  function automatic sat_res_t sat_add(input logic [SAT_W-1:0] a,
                                       input logic [SAT_W-1:0] b,
                                       input int               w);
    logic signed [SAT_W:0] s;
    logic signed [SAT_W:0] hi;
    logic signed [SAT_W:0] lo;
    sat_res_t              r;
    s  = $signed({a[SAT_W-1], a}) + $signed({b[SAT_W-1], b});
    hi = (SAT_ONE <<< (w - 1)) - SAT_ONE;
    lo = -(SAT_ONE <<< (w - 1));
    if (s > hi) begin
      r.clamped = 1'b1;
      r.sum     = hi[SAT_W-1:0];
    end else if (s < lo) begin
      r.clamped = 1'b1;
      r.sum     = lo[SAT_W-1:0];
    end else begin
      r.clamped = 1'b0;
      r.sum     = s[SAT_W-1:0];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/MulSgn.sv
// ============================================================================
//  MulSgn
//  Combinational signed multiplier; speed selects shift-add or array form.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module MulSgn #(
  parameter int         widthX = 8,
  parameter int         widthY = 8,
  parameter logic [1:0] speed  = 2'b10
) (
  input  logic [widthX-1:0]        x,
  input  logic [widthY-1:0]        y,
  output logic [widthX+widthY-1:0] p
);

  localparam int P_W = widthX + widthY;

  logic [P_W-1:0] w_xe;

  assign w_xe = {{widthY{x[widthX-1]}}, x};

  generate
    if (speed == 2'b00) begin : g_shift_add
      // Two's-complement multiplicand: the MSB partial product carries negative weight.
      always_comb begin
        p = '0;
        for (int i = 0; i < widthY; i++) begin
          if (y[i]) begin
            if (i == widthY - 1) p = p - (w_xe << i);
            else                 p = p + (w_xe << i);
          end
        end
      end
    end else begin : g_array
      logic [P_W-1:0] w_ye;
      assign w_ye = {{widthX{y[widthY-1]}}, y};
      assign p    = w_xe * w_ye;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/mul_sgn_acc.sv
// ============================================================================
//  mul_sgn_acc
//  Streaming signed multiply-accumulate with per-frame saturated sum output.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mul_sgn_acc
  import mul_acc_pkg::*;
#(
  parameter int         widthX    = 8,
  parameter int         widthY    = 8,
  parameter int         guardBits = 4,
  parameter logic [1:0] speed     = 2'b10
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic [widthX-1:0]                    in_x_i,
  input  logic [widthY-1:0]                    in_y_i,
  input  logic                                 in_last_i,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [widthX+widthY+guardBits-1:0]   out_acc_o,
  output logic [COUNT_W-1:0]                   out_count_o,
  output logic                                 out_sat_o
);

  localparam int ACC_W = acc_w(widthX, widthY, guardBits);
  localparam int P_W   = widthX + widthY;

  logic [P_W-1:0]         w_p;
  logic [P_W-1:0]         r_s1_p;
  logic                   r_s1_last;
  logic                   r_s1_valid;
  acc_state_e             r_state;
  acc_state_e             w_state_nxt;
  logic [ACC_W-1:0]       r_acc;
  logic [COUNT_W-1:0]     r_count;
  logic                   r_sat;
  logic                   w_s1_adv;
  logic                   w_in_hs;
  logic                   w_out_hs;
  sat_res_t               w_sa;
  logic [SAT_W-ACC_W-1:0] w_unused_hi;

  MulSgn #(
    .widthX (widthX),
    .widthY (widthY),
    .speed  (speed)
  ) u_mul (
    .x (in_x_i),
    .y (in_y_i),
    .p (w_p)
  );

  assign w_s1_adv    = r_s1_valid && (r_state == ACC);
  assign in_ready_o  = !r_s1_valid || w_s1_adv;
  assign w_in_hs     = in_valid_i && in_ready_o;
  assign out_valid_o = (r_state == HOLD);
  assign w_out_hs    = out_valid_o && out_ready_i;

  assign w_sa = sat_add({{(SAT_W-ACC_W){r_acc[ACC_W-1]}}, r_acc},
                        {{(SAT_W-P_W){r_s1_p[P_W-1]}}, r_s1_p},
                        ACC_W);
  assign w_unused_hi = w_sa.sum[SAT_W-1:ACC_W];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ACC;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACC:     if (w_s1_adv && r_s1_last) w_state_nxt = HOLD;
      HOLD:    if (w_out_hs) w_state_nxt = ACC;
      default: w_state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s1_valid <= 1'b0;
      r_s1_p     <= '0;
      r_s1_last  <= 1'b0;
      r_acc      <= '0;
      r_count    <= '0;
      r_sat      <= 1'b0;
    end else begin
      if (w_in_hs) begin
        r_s1_valid <= 1'b1;
        r_s1_p     <= w_p;
        r_s1_last  <= in_last_i;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end

      // Advance (ACC) and result handoff (HOLD) can never coincide.
      if (w_s1_adv) begin
        r_acc   <= w_sa.sum[ACC_W-1:0];
        r_count <= (&r_count) ? r_count : r_count + COUNT_W'(1);
        r_sat   <= r_sat | w_sa.clamped;
      end else if (w_out_hs) begin
        r_acc   <= '0;
        r_count <= '0;
        r_sat   <= 1'b0;
      end
    end
  end

  assign out_acc_o   = r_acc;
  assign out_count_o = r_count;
  assign out_sat_o   = r_sat;

endmodule

`default_nettype wire
